acq_accum_ctrl: RTL and testbench

//  Sequencer for the acquisition accumulator chain: coherent (KG) stage, then non-coherent (NKG) stage.

---
 rtl/acq_accum_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_acq_accum_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_accum_ctrl.sv
// rtl/acq_accum_ctrl.sv - acquisition KG/NKG accumulator chain sequencer with peak search
module acq_accum_ctrl #(
    parameter int N_ARGS     = 64,
    parameter int DATA_WIDTH = 30,
    parameter int KG_WIDTH   = 8,
    parameter int NKG_WIDTH  = 8,
    parameter int TO_WIDTH   = 24,
    localparam int IDX_W     = (N_ARGS > 1) ? $clog2(N_ARGS) : 1
) (
    input  logic                  core_clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KG_WIDTH-1:0]   cfg_kg,
    input  logic [NKG_WIDTH-1:0]  cfg_nkg,
    input  logic                  src_valid,
    output logic                  acc_we,
    output logic                  acc_clr,
    output logic [KG_WIDTH-1:0]   kg,
    output logic [NKG_WIDTH-1:0]  nkg,
    input  logic                  nkg_valid,
    input  logic [DATA_WIDTH-1:0] nkg_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] peak_val,
    output logic [IDX_W-1:0]      peak_idx,
    output logic [IDX_W-1:0]      bin_cnt,
    output logic                  err_cfg,
    output logic                  err_to,
    output logic                  aborted
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IDX_W-1:0]    LAST_BIN = IDX_W'(N_ARGS - 1);
    // Timeout fires when the counter would step onto all-ones.
    localparam logic [TO_WIDTH-1:0] TO_LAST  = {{(TO_WIDTH-1){1'b1}}, 1'b0};

    logic [2:0]                   state_q, state_d;
    logic [KG_WIDTH-1:0]          kg_q, kg_d, kg_cnt_q, kg_cnt_d;
    logic [NKG_WIDTH-1:0]         nkg_q, nkg_d, nkg_cnt_q, nkg_cnt_d;
    logic [IDX_W-1:0]             bin_cnt_q, bin_cnt_d, res_cnt_q, res_cnt_d;
    logic [IDX_W-1:0]             peak_idx_q, peak_idx_d;
    logic signed [DATA_WIDTH-1:0] peak_val_q, peak_val_d;
    logic [TO_WIDTH-1:0]          to_cnt_q, to_cnt_d;
    logic                         res_done_q, res_done_d;
    logic                         err_cfg_q, err_cfg_d, err_to_q, err_to_d;
    logic                         aborted_q, aborted_d, done_q, done_d;
    logic                         busy_q, busy_d, acc_clr_q, acc_clr_d;
    logic                         res_take, res_last;

    // Forwarding gate; abort removes the write in the very cycle it arrives.
    assign acc_we   = src_valid & (state_q == S_RUN) & ~abort;
    // Result beats are taken in RUN or DRAIN until all bins have been seen.
    assign res_take = nkg_valid & ((state_q == S_RUN) | (state_q == S_DRAIN)) & ~res_done_q;
    assign res_last = res_take & (res_cnt_q == LAST_BIN);

    // Next-state, counter, peak tracker and status computation.
    always_comb begin
        state_d    = state_q;
        kg_d       = kg_q;
        nkg_d      = nkg_q;
        kg_cnt_d   = kg_cnt_q;
        nkg_cnt_d  = nkg_cnt_q;
        bin_cnt_d  = bin_cnt_q;
        res_cnt_d  = res_cnt_q;
        res_done_d = res_done_q;
        peak_val_d = peak_val_q;
        peak_idx_d = peak_idx_q;
        to_cnt_d   = to_cnt_q;
        err_cfg_d  = err_cfg_q;
        err_to_d   = err_to_q;
        aborted_d  = aborted_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (cfg_kg != '0 && cfg_nkg != '0) begin
                        kg_d      = cfg_kg;
                        nkg_d     = cfg_nkg;
                        err_cfg_d = 1'b0;
                        err_to_d  = 1'b0;
                        aborted_d = 1'b0;
                        state_d   = S_CLEAR;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                bin_cnt_d  = '0;
                kg_cnt_d   = '0;
                nkg_cnt_d  = '0;
                res_cnt_d  = '0;
                res_done_d = 1'b0;
                peak_val_d = '0;
                peak_idx_d = '0;
                to_cnt_d   = '0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (acc_we) begin
                    if (bin_cnt_q == LAST_BIN) begin
                        bin_cnt_d = '0;
                        if (kg_cnt_q == kg_q - KG_WIDTH'(1)) begin
                            kg_cnt_d = '0;
                            if (nkg_cnt_q == nkg_q - NKG_WIDTH'(1)) begin
                                nkg_cnt_d = '0;
                                to_cnt_d  = '0;
                                state_d   = S_DRAIN;
                            end else begin
                                nkg_cnt_d = nkg_cnt_q + NKG_WIDTH'(1);
                            end
                        end else begin
                            kg_cnt_d = kg_cnt_q + KG_WIDTH'(1);
                        end
                    end else begin
                        bin_cnt_d = bin_cnt_q + IDX_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (res_done_q || res_last) begin
                    state_d = S_DONE;
                end else if (res_take) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_WIDTH'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (res_take) begin
            res_cnt_d = res_cnt_q + IDX_W'(1);
            if (res_last) begin
                res_done_d = 1'b1;
            end
            // Strict compare keeps the lowest index on ties.
            if (res_cnt_q == '0 || $signed(nkg_data) > peak_val_q) begin
                peak_val_d = $signed(nkg_data);
                peak_idx_d = res_cnt_q;
            end
        end
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end
        done_d    = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
        acc_clr_d = (state_d == S_CLEAR);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            kg_q       <= '0;
            nkg_q      <= '0;
            kg_cnt_q   <= '0;
            nkg_cnt_q  <= '0;
            bin_cnt_q  <= '0;
            res_cnt_q  <= '0;
            res_done_q <= 1'b0;
            peak_val_q <= '0;
            peak_idx_q <= '0;
            to_cnt_q   <= '0;
            err_cfg_q  <= 1'b0;
            err_to_q   <= 1'b0;
            aborted_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            acc_clr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            kg_q       <= kg_d;
            nkg_q      <= nkg_d;
            kg_cnt_q   <= kg_cnt_d;
            nkg_cnt_q  <= nkg_cnt_d;
            bin_cnt_q  <= bin_cnt_d;
            res_cnt_q  <= res_cnt_d;
            res_done_q <= res_done_d;
            peak_val_q <= peak_val_d;
            peak_idx_q <= peak_idx_d;
            to_cnt_q   <= to_cnt_d;
            err_cfg_q  <= err_cfg_d;
            err_to_q   <= err_to_d;
            aborted_q  <= aborted_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            acc_clr_q  <= acc_clr_d;
        end
    end

    assign acc_clr  = acc_clr_q;
    assign kg       = kg_q;
    assign nkg      = nkg_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign peak_val = peak_val_q;
    assign peak_idx = peak_idx_q;
    assign bin_cnt  = bin_cnt_q;
    assign err_cfg  = err_cfg_q;
    assign err_to   = err_to_q;
    assign aborted  = aborted_q;

endmodule

// File: tb/tb_acq_accum_ctrl.sv
// tb/tb_acq_accum_ctrl.sv - directed self-checking bench for acq_accum_ctrl
module tb_acq_accum_ctrl;

    logic        core_clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        src_valid = 1'b0;
    logic        nkg_valid = 1'b0;
    logic [7:0]  cfg_kg = 8'd0;
    logic [7:0]  cfg_nkg = 8'd0;
    logic [29:0] nkg_data = '0;
    logic        acc_we, acc_clr, busy, done, err_cfg, err_to, aborted;
    logic [7:0]  kg, nkg;
    logic [29:0] peak_val;
    logic [1:0]  peak_idx, bin_cnt;

    int checks = 0;
    int passed = 0;
    int we_cnt = 0;
    int clr_cnt = 0;
    int done_cnt = 0;
    int bin_err = 0;
    int busy_gap = 0;
    int run_base = 0;
    bit tgl = 1'b0;

    acq_accum_ctrl #(
        .N_ARGS(4), .DATA_WIDTH(30), .KG_WIDTH(8), .NKG_WIDTH(8), .TO_WIDTH(4)
    ) dut (
        .core_clk(core_clk), .resetn(resetn), .start(start), .abort(abort),
        .cfg_kg(cfg_kg), .cfg_nkg(cfg_nkg), .src_valid(src_valid),
        .acc_we(acc_we), .acc_clr(acc_clr), .kg(kg), .nkg(nkg),
        .nkg_valid(nkg_valid), .nkg_data(nkg_data), .busy(busy), .done(done),
        .peak_val(peak_val), .peak_idx(peak_idx), .bin_cnt(bin_cnt),
        .err_cfg(err_cfg), .err_to(err_to), .aborted(aborted)
    );

    always #5 core_clk = ~core_clk;

    // Event counters sampled mid-cycle; bin index is expected to be beat number mod 4.
    always @(negedge core_clk) begin
        if (acc_we) begin
            if (bin_cnt !== 2'((we_cnt - run_base) % 4)) bin_err++;
            if (!busy) busy_gap++;
            we_cnt++;
        end
        if (acc_clr) clr_cnt++;
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] k, input logic [7:0] n);
        cfg_kg = k;
        cfg_nkg = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_we(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (we_cnt - run_base >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
            if (tgl) src_valid = ~src_valid;
        end
    endtask

    task automatic send_beats(input int a, input int b, input int c, input int d);
        int vals [4];
        vals = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            nkg_valid = 1'b1;
            nkg_data = 30'(vals[i]);
            tick();
        end
        nkg_valid = 1'b0;
        nkg_data = '0;
    endtask

    task automatic test_reset();
        logic [55:0] snap;
        src_valid = 1'b1;
        #3;
        snap = {acc_clr, busy, done, err_cfg, err_to, aborted, peak_val, peak_idx, bin_cnt, kg, nkg};
        checks++;
        if (snap !== '0) $display("FAIL reset_outputs got %h want 0", snap); else passed++;
        checks++;
        if (acc_we !== 1'b0) $display("FAIL reset_acc_we got %b want 0", acc_we); else passed++;
        src_valid = 1'b0;
        @(posedge core_clk);
        #1;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic_run();
        int c0, d0, g0, b0;
        bit ok;
        run_base = we_cnt; c0 = clr_cnt; d0 = done_cnt; g0 = busy_gap; b0 = bin_err;
        src_valid = 1'b1;
        pulse_start(8'd2, 8'd3);
        checks++;
        if (acc_clr !== 1'b1 || busy !== 1'b1) $display("FAIL basic_clr_after_start got clr=%b busy=%b want 1 1", acc_clr, busy); else passed++;
        cfg_kg = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (acc_clr !== 1'b0) $display("FAIL basic_clr_one_cycle got %b want 0", acc_clr); else passed++;
        wait_we(24, ok);
        checks++;
        if (!ok) $display("FAIL basic_wait_24 got %0d beats want 24", we_cnt - run_base); else passed++;
        checks++;
        if (kg !== 8'd2 || nkg !== 8'd3) $display("FAIL basic_latched_cfg got kg=%0d nkg=%0d want 2 3", kg, nkg); else passed++;
        send_beats(5, 9, -3, 9);
        checks++;
        if (done !== 1'b1) $display("FAIL basic_done_after_last got %b want 1", done); else passed++;
        checks++;
        if (peak_val !== 30'd9 || peak_idx !== 2'd1) $display("FAIL basic_peak got val=%0d idx=%0d want 9 1", peak_val, peak_idx); else passed++;
        tick();
        src_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done, busy); else passed++;
        repeat (3) tick();
        checks++;
        if (we_cnt - run_base !== 24) $display("FAIL basic_we_count got %0d want 24", we_cnt - run_base); else passed++;
        checks++;
        if (clr_cnt - c0 !== 1 || done_cnt - d0 !== 1) $display("FAIL basic_clr_done_count got clr=%0d done=%0d want 1 1", clr_cnt - c0, done_cnt - d0); else passed++;
        checks++;
        if (busy_gap !== g0 || bin_err !== b0) $display("FAIL basic_busy_bins got gaps=%0d binerr=%0d want 0 0", busy_gap - g0, bin_err - b0); else passed++;
    endtask

    task automatic test_toggle_valid();
        int b0;
        bit ok;
        run_base = we_cnt; b0 = bin_err;
        src_valid = 1'b1;
        tgl = 1'b1;
        pulse_start(8'd2, 8'd3);
        wait_we(24, ok);
        tgl = 1'b0;
        src_valid = 1'b0;
        checks++;
        if (!ok) $display("FAIL toggle_wait_24 got %0d beats want 24", we_cnt - run_base); else passed++;
        send_beats(-7, -2, -2, -5);
        checks++;
        if (peak_val !== 30'h3FFF_FFFE || peak_idx !== 2'd1) $display("FAIL toggle_neg_peak got val=%h idx=%0d want 3ffffffe 1", peak_val, peak_idx); else passed++;
        repeat (3) tick();
        checks++;
        if (we_cnt - run_base !== 24 || bin_err !== b0) $display("FAIL toggle_count_wrap got beats=%0d binerr=%0d want 24 0", we_cnt - run_base, bin_err - b0); else passed++;
    endtask

    task automatic test_cfg_error();
        int c0, d0;
        c0 = clr_cnt; d0 = done_cnt;
        pulse_start(8'd0, 8'd3);
        checks++;
        if (err_cfg !== 1'b1 || busy !== 1'b0) $display("FAIL cfg_err_flag got err=%b busy=%b want 1 0", err_cfg, busy); else passed++;
        repeat (5) tick();
        checks++;
        if (clr_cnt - c0 !== 0 || done_cnt - d0 !== 0 || busy !== 1'b0) $display("FAIL cfg_err_no_run got clr=%0d done=%0d busy=%b want 0 0 0", clr_cnt - c0, done_cnt - d0, busy); else passed++;
    endtask

    task automatic test_abort();
        int c0, d0;
        bit ok;
        run_base = we_cnt; d0 = done_cnt;
        src_valid = 1'b1;
        pulse_start(8'd2, 8'd3);
        checks++;
        if (err_cfg !== 1'b0) $display("FAIL abort_errcfg_cleared got %b want 0", err_cfg); else passed++;
        wait_we(9, ok);
        abort = 1'b1;
        #1;
        checks++;
        if (!ok || acc_we !== 1'b0) $display("FAIL abort_we_drop got we=%b ok=%b want 0 1", acc_we, ok); else passed++;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || aborted !== 1'b1) $display("FAIL abort_idle got busy=%b aborted=%b want 0 1", busy, aborted); else passed++;
        repeat (20) tick();
        checks++;
        if (we_cnt - run_base !== 9 || done_cnt - d0 !== 0) $display("FAIL abort_counts got beats=%0d done=%0d want 9 0", we_cnt - run_base, done_cnt - d0); else passed++;
        c0 = clr_cnt;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || clr_cnt - c0 !== 0) $display("FAIL abort_start_same got busy=%b clr=%0d want 0 0", busy, clr_cnt - c0); else passed++;
        src_valid = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        run_base = we_cnt;
        n = -1;
        src_valid = 1'b1;
        pulse_start(8'd1, 8'd1);
        checks++;
        if (aborted !== 1'b0) $display("FAIL timeout_aborted_cleared got %b want 0", aborted); else passed++;
        wait_we(4, ok);
        src_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (!ok || n !== 15) $display("FAIL timeout_latency got %0d cycles want 15", n); else passed++;
        checks++;
        if (err_to !== 1'b1) $display("FAIL timeout_flag got %b want 1", err_to); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [55:0] snap;
        int d0;
        bit ok;
        run_base = we_cnt;
        src_valid = 1'b1;
        pulse_start(8'd2, 8'd3);
        wait_we(5, ok);
        resetn = 1'b0;
        #1;
        snap = {acc_clr, busy, done, err_cfg, err_to, aborted, peak_val, peak_idx, bin_cnt, kg, nkg};
        checks++;
        if (!ok || snap !== '0 || acc_we !== 1'b0) $display("FAIL midreset_outputs got %h we=%b want 0 0", snap, acc_we); else passed++;
        tick();
        resetn = 1'b1;
        tick();
        run_base = we_cnt; d0 = done_cnt;
        pulse_start(8'd2, 8'd3);
        wait_we(24, ok);
        src_valid = 1'b0;
        send_beats(1, 2, 3, 4);
        checks++;
        if (!ok || done !== 1'b1 || peak_val !== 30'd4 || peak_idx !== 2'd3) $display("FAIL midreset_rerun got done=%b val=%0d idx=%0d want 1 4 3", done, peak_val, peak_idx); else passed++;
        repeat (3) tick();
        checks++;
        if (we_cnt - run_base !== 24 || done_cnt - d0 !== 1) $display("FAIL midreset_counts got beats=%0d done=%0d want 24 1", we_cnt - run_base, done_cnt - d0); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_toggle_valid();
        test_cfg_error();
        test_abort();
        test_timeout();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
